// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: requester/controller bundle (start, limit, repeat_mode, pause, abort, ack in; cnt_en, q, busy, tc, done out; down when COUNTER_SEQ_CTRL_DOWN_EN)
interface counter_seq_ctrl_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             repeat_mode;
  logic             pause;
  logic             abort;
  logic             ack;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
  logic             down;
`endif
  logic             cnt_en;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;
  modport master (
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
    output down,
`endif
    output start, limit, repeat_mode, pause, abort, ack,
    input  cnt_en, q, busy, tc, done
  );
  modport slave (
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
    input  down,
`endif
    input  start, limit, repeat_mode, pause, abort, ack,
    output cnt_en, q, busy, tc, done
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequences a WIDTH-bit counter 0..limit (one-shot or auto-reload) with pause/abort and done/ack; clk, clear (sync active-high), bus (slave); COUNTER_SEQ_CTRL_DOWN_EN adds down-counting
module counter_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic clear,
  counter_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_q, w_q, r_limit, w_load, w_reload, w_step;
  logic             r_repeat, w_accept, w_term;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
  logic             r_down;
  assign w_term   = r_down ? (r_q == '0) : (r_q == r_limit);
  assign w_load   = bus.down ? bus.limit : '0;
  assign w_reload = r_down ? r_limit : '0;
  assign w_step   = r_down ? r_q - 1'b1 : r_q + 1'b1;
`else
  assign w_term   = r_q == r_limit;
  assign w_load   = '0;
  assign w_reload = '0;
  assign w_step   = r_q + 1'b1;
`endif
  assign w_accept   = (r_state == IDLE) & bus.start & ~bus.abort;
  assign bus.cnt_en = (r_state == RUN) & ~bus.pause & ~bus.abort;
  assign bus.tc     = bus.cnt_en & w_term;
  assign bus.busy   = r_state == RUN;
  assign bus.done   = r_state == DONE;
  assign bus.q      = r_q;
  // Priority inside RUN: abort, then terminal hit, then pause/increment (cnt_en already folds in pause).
  always_comb begin
    w_state = r_state;
    w_q     = r_q;
    case (r_state)
      IDLE: begin
        w_q = w_accept ? w_load : '0;
        if (w_accept) w_state = RUN;
      end
      RUN: begin
        if (bus.abort) begin
          w_state = IDLE;
          w_q     = '0;
        end else if (bus.tc) begin
          if (!r_repeat) w_state = DONE;
          w_q = r_repeat ? w_reload : r_q;
        end else if (bus.cnt_en) begin
          w_q = w_step;
        end
      end
      DONE: begin
        if (bus.abort | bus.ack) begin
          w_state = IDLE;
          w_q     = '0;
        end
      end
      default: begin
        w_state = IDLE;
        w_q     = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_limit  <= '0;
      r_repeat <= 1'b0;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
      r_down   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_q     <= w_q;
      if (w_accept) begin
        r_limit  <= bus.limit;
        r_repeat <= bus.repeat_mode;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
        r_down   <= bus.down;
`endif
      end
    end
  end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed and random stimulus against a position-based reference model
module tb_counter_seq_ctrl;
  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  counter_seq_ctrl_if #(.WIDTH(4)) bus ();
  counter_seq_ctrl #(.WIDTH(4)) dut (.clk(clk), .clear(clear), .bus(bus.slave));
  bit dn_in;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
  assign bus.down = dn_in;
`endif
  // Model: sequence position n = non-paused RUN cycles since accept.
  bit m_act, m_fin, m_rep, m_dn;
  int m_n, m_l;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit st, input int lim, input bit rm, input bit pz, input bit ab,
                      input bit ak, input bit cl, input bit dn);
    int qup, eq;
    bit ebusy, een;
    clear = cl;
    bus.start = st;
    bus.limit = lim[3:0];
    bus.repeat_mode = rm;
    bus.pause = pz;
    bus.abort = ab;
    bus.ack = ak;
    dn_in = dn;
    @(negedge clk);
    qup   = m_fin ? m_l : (m_rep ? m_n % (m_l + 1) : m_n);
    eq    = !m_act ? 0 : (m_dn ? m_l - qup : qup);
    ebusy = m_act && !m_fin;
    een   = ebusy && !pz && !ab;
    chk("q", 32'(bus.q), 32'(eq));
    chk("busy", 32'(bus.busy), 32'(ebusy));
    chk("done", 32'(bus.done), 32'(m_fin));
    chk("cnt_en", 32'(bus.cnt_en), 32'(een));
    chk("tc", 32'(bus.tc), 32'(een && qup == m_l));
    @(posedge clk);
    if (cl) begin
      m_act = 0; m_fin = 0; m_rep = 0; m_dn = 0; m_n = 0; m_l = 0;
    end else if (!m_act) begin
      if (st && !ab) begin
        m_act = 1; m_n = 0; m_l = lim; m_rep = rm;
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
        m_dn = dn;
`else
        m_dn = 0;
`endif
      end
    end else if (m_fin) begin
      if (ab || ak) begin m_act = 0; m_fin = 0; end
    end else if (ab) begin
      m_act = 0;
    end else if (!pz) begin
      if (!m_rep && m_n == m_l) m_fin = 1;
      else m_n++;
    end
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    clear = 1'b1;
    bus.start = 1'b0; bus.limit = '0; bus.repeat_mode = 1'b0;
    bus.pause = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0; dn_in = 1'b0;
    @(posedge clk); #1;
    // reset holds with start asserted
    step(1, 7, 0, 0, 0, 0, 1, 0);
    step(1, 7, 0, 0, 0, 0, 1, 0);
    // limit 5 one-shot, ack in cycle 9
    step(1, 5, 0, 0, 0, 0, 0, 0); idle(8);
    step(0, 0, 0, 0, 0, 1, 0, 0); idle(1);
    // limit 3 repeat, abort at q=2
    step(1, 3, 1, 0, 0, 0, 0, 0); idle(6);
    step(0, 0, 0, 0, 1, 0, 0, 0); idle(1);
    // limit 4 one-shot, pause cycles 2-3
    step(1, 4, 0, 0, 0, 0, 0, 0); idle(1);
    step(0, 0, 0, 1, 0, 0, 0, 0); step(0, 0, 0, 1, 0, 0, 0, 0); idle(6);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    // limit 0 one-shot
    step(1, 0, 0, 0, 0, 0, 0, 0); idle(3);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    // limit 15 repeat: full range with wrap
    step(1, 15, 1, 0, 0, 0, 0, 0); idle(18);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    // abort coincident with q==limit
    step(1, 2, 0, 0, 0, 0, 0, 0); idle(2);
    step(0, 0, 0, 0, 1, 0, 0, 0); idle(2);
    // start together with ack in DONE is ignored
    step(1, 1, 0, 0, 0, 0, 0, 0); idle(3);
    step(1, 9, 0, 0, 0, 1, 0, 0); idle(2);
    // pause coincident with q==limit
    step(1, 1, 0, 0, 0, 0, 0, 0); idle(1);
    step(0, 0, 0, 1, 0, 0, 0, 0); idle(2);
    step(0, 0, 0, 0, 0, 1, 0, 0);
`ifdef COUNTER_SEQ_CTRL_DOWN_EN
    step(1, 6, 0, 0, 0, 0, 0, 1); idle(9);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0, 1); idle(7);
    step(0, 0, 0, 0, 1, 0, 0, 0);
`endif
    for (int i = 0; i < 2000; i++)
      step($urandom % 3 == 0, $urandom_range(0, 15), $urandom % 2 == 0, $urandom % 5 == 0,
           $urandom % 20 == 0, $urandom % 4 == 0, $urandom % 50 == 0, $urandom % 2 == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
